// File: rtl/md_sequencer.sv
// Iterative multiply/divide sequencer feeding the architectural HI/LO registers.
// Shift-add multiply and restoring divide (one bit per cycle), then a sign-fix cycle.
module md_sequencer #(
   parameter int W     = 32,
   parameter int CNT_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         EX_MDStart,
   input  logic [2:0]   EX_MDOp,
   input  logic [W-1:0] EX_OpA,
   input  logic [W-1:0] EX_OpB,
   input  logic         EX_Flush,
   output logic         MD_Busy,
   output logic         MD_Done,
   output logic         MD_DivZero,
   output logic [W-1:0] MD_Hi,
   output logic [W-1:0] MD_Lo
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     wh_q, wh_d;      // MUL: accumulator, DIV: remainder
   logic [W-1:0]     wl_q, wl_d;      // MUL: multiplier,  DIV: quotient
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     a_q, a_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic             is_div_q, is_div_d;
   logic             divz_q, divz_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   logic             signed_op;
   logic [W-1:0]     abs_a, abs_b;
   logic [W:0]       mul_sum;
   logic [W+1:0]     div_shift, div_diff;
   logic [2*W-1:0]   prod, prod_neg;

   assign signed_op = ~EX_MDOp[0];
   assign abs_a     = (signed_op && EX_OpA[W-1]) ? -EX_OpA : EX_OpA;
   assign abs_b     = (signed_op && EX_OpB[W-1]) ? -EX_OpB : EX_OpB;
   assign mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {1'b0, wh_q, wl_q[W-1]};
   assign div_diff  = div_shift - {2'b00, b_q};
   assign prod      = {wh_q, wl_q};
   assign prod_neg  = -prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wh_d     = wh_q;
      wl_d     = wl_q;
      b_d      = b_q;
      a_d      = a_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;
      is_div_d = is_div_q;
      divz_d   = divz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (EX_MDStart && !EX_Flush) begin
               case (EX_MDOp)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     wh_d     = '0;
                     wl_d     = abs_a;
                     b_d      = abs_b;
                     a_d      = EX_OpA;
                     qsign_d  = signed_op & (EX_OpA[W-1] ^ EX_OpB[W-1]);
                     rsign_d  = signed_op & EX_OpA[W-1];
                     is_div_d = EX_MDOp[1];
                     divz_d   = EX_MDOp[1] & (EX_OpB == '0);
                     cnt_d    = CNT_W'(W-1);
                     busy_d   = 1'b1;
                     state_d  = EX_MDOp[1] ? S_DIV : S_MUL;
                  end
                  3'b100:  hi_d = EX_OpA;
                  3'b101:  lo_d = EX_OpA;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            wh_d = mul_sum[W:1];
            wl_d = {mul_sum[0], wl_q[W-1:1]};
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_DIV: begin
            // Restoring step: keep the trial difference only when it did not borrow.
            if (!div_diff[W+1]) begin
               wh_d = div_diff[W-1:0];
               wl_d = {wl_q[W-2:0], 1'b1};
            end else begin
               wh_d = div_shift[W-1:0];
               wl_d = {wl_q[W-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            if (is_div_q) begin
               if (divz_q) begin
                  lo_d = '1;
                  hi_d = a_q;
               end else begin
                  lo_d = qsign_q ? -wl_q : wl_q;
                  hi_d = rsign_q ? -wh_q : wh_q;
               end
            end else begin
               {hi_d, lo_d} = qsign_q ? prod_neg : prod;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dz_d    = is_div_q & divz_q;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
      // A squash of the in-flight op discards it without touching HI/LO.
      if (EX_Flush && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         dz_d    = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wh_q     <= '0;
         wl_q     <= '0;
         b_q      <= '0;
         a_q      <= '0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         is_div_q <= 1'b0;
         divz_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wh_q     <= wh_d;
         wl_q     <= wl_d;
         b_q      <= b_d;
         a_q      <= a_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
         is_div_q <= is_div_d;
         divz_q   <= divz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign MD_Busy    = busy_q;
   assign MD_Done    = done_q;
   assign MD_DivZero = dz_q;
   assign MD_Hi      = hi_q;
   assign MD_Lo      = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: one task per scenario, hand-computed HI/LO values.
module tb_md_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        EX_MDStart;
   logic [2:0]  EX_MDOp;
   logic [31:0] EX_OpA, EX_OpB;
   logic        EX_Flush;
   logic        MD_Busy, MD_Done, MD_DivZero;
   logic [31:0] MD_Hi, MD_Lo;

   int total = 0;
   int passed = 0;

   localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                          OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

   md_sequencer #(.W(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .EX_MDStart(EX_MDStart), .EX_MDOp(EX_MDOp),
      .EX_OpA(EX_OpA), .EX_OpB(EX_OpB), .EX_Flush(EX_Flush),
      .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_DivZero(MD_DivZero),
      .MD_Hi(MD_Hi), .MD_Lo(MD_Lo)
   );

   always #5 clk = ~clk;

   // Presents an op for one cycle; returns at the negedge just after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      EX_MDStart = 1'b1; EX_MDOp = op; EX_OpA = a; EX_OpB = b;
      @(negedge clk);
      EX_MDStart = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
      int n;
      issue(op, a, b);
      n = 0;
      while (MD_Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      total++; if (n !== 33) $display("FAIL %s busy_cycles got %0d want 33", nm, n); else passed++;
      total++; if (MD_Done !== 1'b1) $display("FAIL %s done got %b want 1", nm, MD_Done); else passed++;
      total++; if (MD_DivZero !== edz) $display("FAIL %s divzero got %b want %b", nm, MD_DivZero, edz); else passed++;
      total++; if (MD_Hi !== ehi) $display("FAIL %s hi got %h want %h", nm, MD_Hi, ehi); else passed++;
      total++; if (MD_Lo !== elo) $display("FAIL %s lo got %h want %h", nm, MD_Lo, elo); else passed++;
      @(negedge clk);
      total++; if ({MD_Done, MD_DivZero} !== 2'b00) $display("FAIL %s pulse_end got %b want 00", nm, {MD_Done, MD_DivZero}); else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b1; EX_MDStart = 1'b0; EX_MDOp = 3'b000; EX_OpA = '0; EX_OpB = '0; EX_Flush = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if ({MD_Busy, MD_Done, MD_DivZero} !== 3'b000) $display("FAIL reset flags got %b want 000", {MD_Busy, MD_Done, MD_DivZero}); else passed++;
      total++; if ({MD_Hi, MD_Lo} !== 64'h0) $display("FAIL reset hilo got %h want 0", {MD_Hi, MD_Lo}); else passed++;
   endtask

   task automatic test_mt;
      issue(OP_MTHI, 32'h0000_1234, 32'h0);
      total++; if (MD_Hi !== 32'h0000_1234) $display("FAIL mthi hi got %h want 00001234", MD_Hi); else passed++;
      total++; if ({MD_Busy, MD_Done} !== 2'b00) $display("FAIL mthi flags got %b want 00", {MD_Busy, MD_Done}); else passed++;
      issue(OP_MTLO, 32'hCAFE_0001, 32'h0);
      total++; if (MD_Lo !== 32'hCAFE_0001) $display("FAIL mtlo lo got %h want cafe0001", MD_Lo); else passed++;
      issue(3'b110, 32'hBAD0_BAD0, 32'h0);
      total++; if ({MD_Busy, MD_Hi, MD_Lo} !== {1'b0, 32'h0000_1234, 32'hCAFE_0001}) $display("FAIL reserved state got %b %h %h want 0 00001234 cafe0001", MD_Busy, MD_Hi, MD_Lo); else passed++;
   endtask

   task automatic test_mul;
      run_op("mult_7xm3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult_max_signed", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
   endtask

   task automatic test_div;
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
   endtask

   task automatic test_flush;
      issue(OP_MTHI, 32'h0000_1234, 32'h0);
      issue(OP_MULT, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      EX_Flush = 1'b1;
      @(negedge clk);
      EX_Flush = 1'b0;
      total++; if ({MD_Busy, MD_Done} !== 2'b00) $display("FAIL flush flags got %b want 00", {MD_Busy, MD_Done}); else passed++;
      total++; if (MD_Hi !== 32'h0000_1234) $display("FAIL flush hi got %h want 00001234", MD_Hi); else passed++;
      EX_MDStart = 1'b1; EX_MDOp = OP_MTLO; EX_OpA = 32'h0000_5678;
      @(negedge clk);
      EX_MDStart = 1'b0;
      total++; if (MD_Lo !== 32'h0000_5678) $display("FAIL mtlo_after_flush lo got %h want 00005678", MD_Lo); else passed++;
      repeat (40) @(negedge clk);
      total++; if (MD_Done !== 1'b0 || MD_Hi !== 32'h0000_1234) $display("FAIL flush_no_late_done done %b hi %h want 0 00001234", MD_Done, MD_Hi); else passed++;
      // flush alongside a start in IDLE suppresses even MTHI
      @(negedge clk);
      EX_MDStart = 1'b1; EX_MDOp = OP_MTHI; EX_OpA = 32'hDEAD_BEEF; EX_Flush = 1'b1;
      @(negedge clk);
      EX_MDStart = 1'b0; EX_Flush = 1'b0;
      total++; if ({MD_Busy, MD_Hi} !== {1'b0, 32'h0000_1234}) $display("FAIL flush_idle got %b %h want 0 00001234", MD_Busy, MD_Hi); else passed++;
   endtask

   task automatic test_reset_mid;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
      repeat (19) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      total++; if ({MD_Busy, MD_Done, MD_Hi, MD_Lo} !== 66'h0) $display("FAIL reset_mid got %b %b %h %h want 0 0 0 0", MD_Busy, MD_Done, MD_Hi, MD_Lo); else passed++;
      @(negedge clk);
      rst = 1'b0;
      run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
   endtask

   task automatic test_back_to_back;
      int n;
      issue(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
      // a start while busy must be ignored entirely
      EX_MDStart = 1'b1; EX_MDOp = OP_MTHI; EX_OpA = 32'h1111_1111;
      @(negedge clk);
      EX_MDStart = 1'b0;
      n = 1;
      while (MD_Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      total++; if (n !== 33) $display("FAIL b2b busy_cycles got %0d want 33", n); else passed++;
      total++; if ({MD_Done, MD_Hi, MD_Lo} !== {1'b1, 32'h0000_0003, 32'h0}) $display("FAIL b2b result got %b %h %h want 1 00000003 00000000", MD_Done, MD_Hi, MD_Lo); else passed++;
      EX_MDStart = 1'b1; EX_MDOp = OP_DIVU; EX_OpA = 32'd50; EX_OpB = 32'd8;
      @(negedge clk);
      EX_MDStart = 1'b0;
      total++; if ({MD_Busy, MD_Done} !== 2'b10) $display("FAIL b2b restart flags got %b want 10", {MD_Busy, MD_Done}); else passed++;
      n = 0;
      while (MD_Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      total++; if ({n[7:0], MD_Hi, MD_Lo} !== {8'd33, 32'd2, 32'd6}) $display("FAIL b2b divu got %0d %h %h want 33 2 6", n, MD_Hi, MD_Lo); else passed++;
   endtask

   initial begin
      test_reset();
      test_mt();
      test_mul();
      test_div();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
